// File: rtl/l2_per_bridge_router.sv
// Peripheral-side router behind the L2 demux: decodes one request against N address
// ranges, forwards it to the matching bridge, and returns its response or an error.
module l2_per_bridge_router #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BE_WIDTH       = DATA_WIDTH / 8,
  parameter int TAG_WIDTH      = DATA_WIDTH / 8,
  parameter int AUX_WIDTH      = 4,
  parameter int N_PERIPHS      = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                  clk,
  input  logic                                  rst_n,

  input  logic                                  data_req_i,
  input  logic [ADDR_WIDTH-1:0]                 data_add_i,
  input  logic                                  data_wen_i,
  input  logic [DATA_WIDTH-1:0]                 data_wdata_i,
  input  logic [TAG_WIDTH-1:0]                  data_wtag_i,
  input  logic [BE_WIDTH-1:0]                   data_be_i,
  input  logic [AUX_WIDTH-1:0]                  data_aux_i,
  output logic                                  data_gnt_o,
  output logic                                  data_r_valid_o,
  output logic [DATA_WIDTH-1:0]                 data_r_rdata_o,
  output logic [TAG_WIDTH-1:0]                  data_r_rtag_o,
  output logic                                  data_r_opc_o,
  output logic [AUX_WIDTH-1:0]                  data_r_aux_o,

  output logic [N_PERIPHS-1:0]                  per_req_o,
  output logic [ADDR_WIDTH-1:0]                 per_add_o,
  output logic                                  per_wen_o,
  output logic [DATA_WIDTH-1:0]                 per_wdata_o,
  output logic [BE_WIDTH-1:0]                   per_be_o,
  input  logic [N_PERIPHS-1:0]                  per_gnt_i,
  input  logic [N_PERIPHS-1:0]                  per_r_valid_i,
  input  logic [N_PERIPHS-1:0][DATA_WIDTH-1:0]  per_r_rdata_i,
  input  logic [N_PERIPHS-1:0]                  per_r_opc_i,

  input  logic [N_PERIPHS-1:0][ADDR_WIDTH-1:0]  PER_START_ADDR,
  input  logic [N_PERIPHS-1:0][ADDR_WIDTH-1:0]  PER_END_ADDR,

  output logic                                  err_timeout_o
);

  localparam int SEL_W = (N_PERIPHS > 1) ? $clog2(N_PERIPHS) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [31:0]           ERR_WORD  = 32'hBADACCE5;
  localparam logic [DATA_WIDTH-1:0] ERR_RDATA = DATA_WIDTH'(ERR_WORD);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_RESP = 2'd1;
  localparam logic [1:0] S_ERR_RESP  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [SEL_W-1:0]     sel_q;
  logic [AUX_WIDTH-1:0] aux_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [CNT_W-1:0]     cnt_q;

  logic                 hit;
  logic [SEL_W-1:0]     hit_idx;
  logic                 sel_valid;
  logic                 timeout_hit;

  // Request payload is broadcast; only per_req_o qualifies it.
  assign per_add_o   = data_add_i;
  assign per_wen_o   = data_wen_i;
  assign per_wdata_o = data_wdata_i;
  assign per_be_o    = data_be_i;

  assign data_r_aux_o = aux_q;
  assign sel_valid    = per_r_valid_i[sel_q];
  assign timeout_hit  = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

  // Scanning from the top down lets the lowest matching index overwrite the rest.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = N_PERIPHS - 1; k >= 0; k--) begin
      if ((data_add_i >= PER_START_ADDR[k]) && (data_add_i < PER_END_ADDR[k])) begin
        hit     = 1'b1;
        hit_idx = SEL_W'(k);
      end
    end
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d        = state_q;
    per_req_o      = '0;
    data_gnt_o     = 1'b0;
    data_r_valid_o = 1'b0;
    data_r_rdata_o = '0;
    data_r_opc_o   = 1'b0;
    data_r_rtag_o  = '0;
    err_timeout_o  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (data_req_i) begin
          if (hit) begin
            per_req_o[hit_idx] = 1'b1;
            data_gnt_o         = per_gnt_i[hit_idx];
            if (per_gnt_i[hit_idx]) state_d = S_WAIT_RESP;
          end else begin
            data_gnt_o = 1'b1;
            state_d    = S_ERR_RESP;
          end
        end
      end
      S_WAIT_RESP: begin
        if (sel_valid) begin
          data_r_valid_o = 1'b1;
          data_r_rdata_o = per_r_rdata_i[sel_q];
          data_r_opc_o   = per_r_opc_i[sel_q];
          data_r_rtag_o  = tag_q;
          state_d        = S_IDLE;
        end else if (timeout_hit) begin
          err_timeout_o = 1'b1;
          state_d       = S_ERR_RESP;
        end
      end
      S_ERR_RESP: begin
        data_r_valid_o = 1'b1;
        data_r_rdata_o = ERR_RDATA;
        data_r_opc_o   = 1'b1;
        data_r_rtag_o  = tag_q;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // IDLE handshakes are combinational from data_req_i, so reset must mask them too.
    if (!rst_n) begin
      per_req_o      = '0;
      data_gnt_o     = 1'b0;
      data_r_valid_o = 1'b0;
      data_r_rdata_o = '0;
      data_r_opc_o   = 1'b0;
      data_r_rtag_o  = '0;
      err_timeout_o  = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      aux_q   <= '0;
      tag_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (data_req_i && data_gnt_o) begin
            aux_q <= data_aux_i;
            tag_q <= data_wtag_i;
            if (hit) begin
              sel_q <= hit_idx;
              cnt_q <= '0;
            end
          end
        end
        S_WAIT_RESP: begin
          if (!sel_valid) cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_per_bridge_router.sv
// Directed bench for l2_per_bridge_router: decode, handshake, error and timeout
// responses, overlap priority and asynchronous reset, with hand-computed expectations.
module tb_l2_per_bridge_router;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int TW = 4;
  localparam int XW = 4;
  localparam int NP = 2;

  logic                   clk;
  logic                   rst_n;
  logic                   req;
  logic [AW-1:0]          add;
  logic                   wen;
  logic [DW-1:0]          wdata;
  logic [TW-1:0]          wtag;
  logic [BW-1:0]          be;
  logic [XW-1:0]          aux;
  logic                   gnt;
  logic                   r_valid;
  logic [DW-1:0]          r_rdata;
  logic [TW-1:0]          r_rtag;
  logic                   r_opc;
  logic [XW-1:0]          r_aux;
  logic [NP-1:0]          per_req;
  logic [AW-1:0]          per_add;
  logic                   per_wen;
  logic [DW-1:0]          per_wdata;
  logic [BW-1:0]          per_be;
  logic [NP-1:0]          per_gnt;
  logic [NP-1:0]          per_r_valid;
  logic [NP-1:0][DW-1:0]  per_r_rdata;
  logic [NP-1:0]          per_r_opc;
  logic [NP-1:0][AW-1:0]  per_start;
  logic [NP-1:0][AW-1:0]  per_end;
  logic                   err_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  l2_per_bridge_router #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .BE_WIDTH       (BW),
    .TAG_WIDTH      (TW),
    .AUX_WIDTH      (XW),
    .N_PERIPHS      (NP),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_req_i     (req),
    .data_add_i     (add),
    .data_wen_i     (wen),
    .data_wdata_i   (wdata),
    .data_wtag_i    (wtag),
    .data_be_i      (be),
    .data_aux_i     (aux),
    .data_gnt_o     (gnt),
    .data_r_valid_o (r_valid),
    .data_r_rdata_o (r_rdata),
    .data_r_rtag_o  (r_rtag),
    .data_r_opc_o   (r_opc),
    .data_r_aux_o   (r_aux),
    .per_req_o      (per_req),
    .per_add_o      (per_add),
    .per_wen_o      (per_wen),
    .per_wdata_o    (per_wdata),
    .per_be_o       (per_be),
    .per_gnt_i      (per_gnt),
    .per_r_valid_i  (per_r_valid),
    .per_r_rdata_i  (per_r_rdata),
    .per_r_opc_i    (per_r_opc),
    .PER_START_ADDR (per_start),
    .PER_END_ADDR   (per_end),
    .err_timeout_o  (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic quiet();
    req         = 1'b0;
    add         = '0;
    wen         = 1'b0;
    wdata       = '0;
    wtag        = '0;
    be          = '0;
    aux         = '0;
    per_gnt     = '0;
    per_r_valid = '0;
    per_r_rdata = '0;
    per_r_opc   = '0;
  endtask

  task automatic std_ranges();
    per_start[0] = 32'h1A10_0000; per_end[0] = 32'h1A11_0000;
    per_start[1] = 32'h1A11_0000; per_end[1] = 32'h1A12_0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    quiet();
    std_ranges();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    req = 1'b1; add = 32'h1A10_4000; per_gnt = 2'b01;
    settle();
    check("rst_gnt",     gnt,         1'b0);
    check("rst_per_req", per_req,     2'b00);
    check("rst_r_valid", r_valid,     1'b0);
    check("rst_aux",     r_aux,       4'h0);
    check("rst_timeout", err_timeout, 1'b0);
    quiet();
    next_cycle();
    rst_n = 1'b1;
    settle();
    check("idle_r_valid", r_valid, 1'b0);
    check("idle_rdata",   r_rdata, 32'h0);
    next_cycle();

    // Read to P0, response three cycles after the grant
    req = 1'b1; add = 32'h1A10_4000; wen = 1'b1; aux = 4'h5; wtag = 4'h3; per_gnt = 2'b01;
    settle();
    check("rd_per_req", per_req, 2'b01);
    check("rd_gnt",     gnt,     1'b1);
    check("rd_per_add", per_add, 32'h1A10_4000);
    check("rd_per_wen", per_wen, 1'b1);
    next_cycle();
    quiet();
    settle();
    check("rd_w1_per_req", per_req, 2'b00);
    check("rd_w1_r_valid", r_valid, 1'b0);
    check("rd_w1_rtag",    r_rtag,  4'h0);
    check("rd_w1_aux",     r_aux,   4'h5);
    next_cycle();
    req = 1'b1; add = 32'h1A11_8000; per_gnt = 2'b11;
    settle();
    check("rd_stall_gnt",     gnt,     1'b0);
    check("rd_stall_per_req", per_req, 2'b00);
    check("rd_w2_r_valid",    r_valid, 1'b0);
    next_cycle();
    quiet();
    per_r_valid = 2'b01; per_r_rdata[0] = 32'hCAFE_F00D; per_r_rdata[1] = 32'h1111_1111;
    settle();
    check("rd_r_valid", r_valid, 1'b1);
    check("rd_rdata",   r_rdata, 32'hCAFE_F00D);
    check("rd_aux",     r_aux,   4'h5);
    check("rd_rtag",    r_rtag,  4'h3);
    check("rd_opc",     r_opc,   1'b0);
    next_cycle();
    quiet();
    settle();
    check("rd_done_r_valid", r_valid, 1'b0);
    check("rd_done_rdata",   r_rdata, 32'h0);
    check("rd_done_aux",     r_aux,   4'h5);

    // Decode boundaries, requests withdrawn before the edge
    req = 1'b1; add = 32'h1A11_0000;
    settle();
    check("dec_p1_start", per_req, 2'b10);
    check("dec_p1_nognt", gnt,     1'b0);
    add = 32'h1A10_FFFF;
    #1;
    check("dec_p0_last", per_req, 2'b01);
    add = 32'h1A12_0000;
    #1;
    check("dec_p1_end_per_req", per_req, 2'b00);
    check("dec_p1_end_gnt",     gnt,     1'b1);
    req = 1'b0;
    next_cycle();

    // Write to P1, grant held off for four cycles, error opcode in response
    req = 1'b1; add = 32'h1A11_8000; wen = 1'b0; wdata = 32'h1234_5678; be = 4'hC;
    aux = 4'h6; wtag = 4'h1; per_gnt = 2'b00;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("wr_wait_per_req", per_req, 2'b10);
      check("wr_wait_gnt",     gnt,     1'b0);
      next_cycle();
    end
    per_gnt = 2'b10;
    settle();
    check("wr_gnt",       gnt,       1'b1);
    check("wr_per_wdata", per_wdata, 32'h1234_5678);
    check("wr_per_be",    per_be,    4'hC);
    check("wr_per_wen",   per_wen,   1'b0);
    next_cycle();
    quiet();
    per_r_valid = 2'b10; per_r_opc = 2'b10; per_r_rdata[1] = 32'h0000_00AB;
    settle();
    check("wr_r_valid", r_valid, 1'b1);
    check("wr_opc",     r_opc,   1'b1);
    check("wr_rdata",   r_rdata, 32'h0000_00AB);
    check("wr_rtag",    r_rtag,  4'h1);
    check("wr_aux",     r_aux,   4'h6);
    next_cycle();

    // Unmapped access, issued right after the previous response
    quiet();
    req = 1'b1; add = 32'h0000_0000; wen = 1'b1; aux = 4'hA; wtag = 4'h2;
    settle();
    check("um_gnt",     gnt,     1'b1);
    check("um_per_req", per_req, 2'b00);
    next_cycle();
    settle();
    check("um_r_valid", r_valid, 1'b1);
    check("um_opc",     r_opc,   1'b1);
    check("um_rdata",   r_rdata, 32'hBADA_CCE5);
    check("um_aux",     r_aux,   4'hA);
    check("um_rtag",    r_rtag,  4'h2);
    check("um_gnt_err", gnt,     1'b0);
    check("um_per_req_err", per_req, 2'b00);
    next_cycle();
    quiet();
    settle();
    check("um_done_r_valid", r_valid, 1'b0);

    // Timeout on P0: pulse eight cycles after the grant, error response next
    next_cycle();
    req = 1'b1; add = 32'h1A10_0010; aux = 4'h7; wtag = 4'h4; per_gnt = 2'b01;
    settle();
    check("to_gnt", gnt, 1'b1);
    next_cycle();
    quiet();
    for (int i = 1; i < 8; i++) begin
      settle();
      check("to_wait_timeout", err_timeout, 1'b0);
      check("to_wait_r_valid", r_valid,     1'b0);
      next_cycle();
    end
    settle();
    check("to_pulse",         err_timeout, 1'b1);
    check("to_pulse_r_valid", r_valid,     1'b0);
    next_cycle();
    settle();
    check("to_err_timeout", err_timeout, 1'b0);
    check("to_err_r_valid", r_valid,     1'b1);
    check("to_err_opc",     r_opc,       1'b1);
    check("to_err_rdata",   r_rdata,     32'hBADA_CCE5);
    check("to_err_aux",     r_aux,       4'h7);
    check("to_err_rtag",    r_rtag,      4'h4);
    next_cycle();
    per_r_valid = 2'b01; per_r_rdata[0] = 32'hDEAD_0001;
    settle();
    check("to_stray_r_valid", r_valid, 1'b0);
    check("to_stray_rdata",   r_rdata, 32'h0);
    next_cycle();
    quiet();

    // Overlapping ranges: lowest index wins, other port's valid ignored
    per_start[0] = 32'h100; per_end[0] = 32'h200;
    per_start[1] = 32'h100; per_end[1] = 32'h200;
    req = 1'b1; add = 32'h150; aux = 4'h3; wtag = 4'h5; per_gnt = 2'b11;
    settle();
    check("ov_per_req", per_req, 2'b01);
    check("ov_gnt",     gnt,     1'b1);
    next_cycle();
    quiet();
    per_r_valid = 2'b10; per_r_rdata[1] = 32'h0BAD_0BAD;
    settle();
    check("ov_other_r_valid", r_valid, 1'b0);
    next_cycle();
    quiet();
    per_r_valid = 2'b01; per_r_rdata[0] = 32'h0000_55AA;
    settle();
    check("ov_r_valid", r_valid, 1'b1);
    check("ov_rdata",   r_rdata, 32'h0000_55AA);
    check("ov_rtag",    r_rtag,  4'h5);
    next_cycle();
    quiet();

    // Empty range on P0 never matches
    per_start[0] = 32'h200; per_end[0] = 32'h100;
    req = 1'b1; add = 32'h150;
    settle();
    check("empty_per_req", per_req, 2'b10);
    req = 1'b0;
    next_cycle();

    // Asynchronous reset in the middle of WAIT_RESP
    std_ranges();
    req = 1'b1; add = 32'h1A10_4000; aux = 4'h9; wtag = 4'h6; per_gnt = 2'b01;
    settle();
    check("rs_gnt", gnt, 1'b1);
    next_cycle();
    per_r_valid = 2'b01; per_r_rdata[0] = 32'h7777_7777;
    #1;
    check("rs_pre_r_valid", r_valid, 1'b1);
    check("rs_pre_aux",     r_aux,   4'h9);
    rst_n = 1'b0;
    #1;
    check("rs_r_valid", r_valid, 1'b0);
    check("rs_rdata",   r_rdata, 32'h0);
    check("rs_rtag",    r_rtag,  4'h0);
    check("rs_aux",     r_aux,   4'h0);
    check("rs_gnt_low", gnt,     1'b0);
    check("rs_per_req", per_req, 2'b00);
    next_cycle();
    quiet();
    next_cycle();
    rst_n = 1'b1;
    settle();
    check("rs_after_r_valid", r_valid, 1'b0);
    next_cycle();
    req = 1'b1; add = 32'h1A11_8000; aux = 4'hB; wtag = 4'h7; per_gnt = 2'b10;
    settle();
    check("rs_new_per_req", per_req, 2'b10);
    check("rs_new_gnt",     gnt,     1'b1);
    next_cycle();
    quiet();
    per_r_valid = 2'b10; per_r_rdata[1] = 32'h0000_600D;
    settle();
    check("rs_new_r_valid", r_valid, 1'b1);
    check("rs_new_rdata",   r_rdata, 32'h0000_600D);
    check("rs_new_aux",     r_aux,   4'hB);
    check("rs_new_rtag",    r_rtag,  4'h7);
    next_cycle();
    quiet();
    settle();
    check("rs_new_done", r_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/l2_per_bridge_router.md
Name: l2_per_bridge_router

Overview:
- Sits directly downstream of the L2 core-side demux, on its peripheral (PER) port.
- Accepts one request at a time in req/gnt + r_valid form and decodes the address against N_PERIPHS ranges.
- Forwards the request to the matching peripheral bridge and returns that bridge's response with the captured aux/tag.
- Generates an error response for unmapped addresses and for peripherals that never answer (timeout).

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width
BE_WIDTH, DATA_WIDTH/8, byte-enable width
TAG_WIDTH, DATA_WIDTH/8, tag width
AUX_WIDTH, 4, aux sideband width
N_PERIPHS, 2, number of peripheral ports (>=1)
TIMEOUT_CYCLES, 256, max cycles waiting for r_valid; 0 disables timeout

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
data_req_i  in  1  request from demux
data_add_i  in  ADDR_WIDTH  address
data_wen_i  in  1  1=read, 0=write
data_wdata_i  in  DATA_WIDTH  write data
data_wtag_i  in  TAG_WIDTH  write tag
data_be_i  in  BE_WIDTH  byte enables
data_aux_i  in  AUX_WIDTH  aux sideband
data_gnt_o  out  1  grant
data_r_valid_o  out  1  response valid
data_r_rdata_o  out  DATA_WIDTH  response data
data_r_rtag_o  out  TAG_WIDTH  response tag
data_r_opc_o  out  1  response error
data_r_aux_o  out  AUX_WIDTH  response aux
per_req_o  out  N_PERIPHS  one-hot request per peripheral
per_add_o, per_wen_o, per_wdata_o, per_be_o  out  as inputs  broadcast request payload
per_gnt_i  in  N_PERIPHS  per-peripheral grant
per_r_valid_i  in  N_PERIPHS  per-peripheral response valid
per_r_rdata_i  in  N_PERIPHS x DATA_WIDTH  per-peripheral response data
per_r_opc_i  in  N_PERIPHS  per-peripheral response error
PER_START_ADDR  in  N_PERIPHS x ADDR_WIDTH  range start, inclusive
PER_END_ADDR  in  N_PERIPHS x ADDR_WIDTH  range end, exclusive
err_timeout_o  out  1  one-cycle pulse on timeout

Behaviour:
- Decode (combinational):
  - match[k] = (add >= START[k]) && (add < END[k]).
  - Lowest matching index wins.
  - Empty range (START >= END) never matches.
- State machine: IDLE, WAIT_RESP, ERR_RESP. Reset: IDLE; sel, aux, tag and timeout counter registers are all 0.
- All outputs under reset are 0. per_* payload is always a direct copy of the data_* inputs.
- When data_r_valid_o=0: rdata, opc and rtag are 0; aux holds its captured value.
- IDLE:
  - req with a match k: per_req_o[k]=1, data_gnt_o=per_gnt_i[k].
    - On grant: capture sel=k, aux, tag; clear counter; go to WAIT_RESP.
    - No grant: stay in IDLE; the request may change or drop.
  - req with no match: data_gnt_o=1, capture aux and tag, go to ERR_RESP.
  - per_r_valid_i is ignored (stray responses are dropped).
- WAIT_RESP:
  - data_gnt_o=0 and per_req_o=0: single outstanding transaction, new requests are stalled.
  - Response path is zero-latency, combinational from the selected peripheral:
    - r_valid = per_r_valid_i[sel], rdata = per_r_rdata_i[sel], opc = per_r_opc_i[sel].
    - rtag = captured tag; aux = captured aux.
  - On valid: go to IDLE.
  - Valids from non-selected ports are ignored.
  - Counter increments each cycle without valid. When it reaches TIMEOUT_CYCLES-1 with no valid: pulse err_timeout_o, go to ERR_RESP.
  - If valid arrives in that same cycle, valid wins: normal response, no timeout.
- ERR_RESP (exactly one cycle):
  - r_valid=1, opc=1.
  - rdata = 32'hBAD_ACCE5, zero-extended or truncated to DATA_WIDTH.
  - rtag and aux = captured values.
  - Go to IDLE; gnt=0 this cycle.
- A late response from a timed-out peripheral arrives in IDLE or in a later WAIT_RESP on another sel and is ignored. Same-peripheral late response: documented limitation, software must reset the peripheral.
- Reset asserted mid-transaction: immediately IDLE with all outputs 0; the pending response is lost.
- Minimum turnaround: grant at cycle t, response at t+1 earliest, next grant at t+2 earliest.

Test Plan:
- Ranges P0=[0x1A100000,0x1A110000), P1=[0x1A110000,0x1A120000). Read 0x1A104000, aux=0x5, tag=0x3; per_gnt_i[0]=1; per_r_valid_i[0] 3 cycles later with rdata 0xCAFEF00D -> per_req_o=01 for one cycle, data_r_valid_o for one cycle with rdata 0xCAFEF00D, aux 0x5, tag 0x3, opc 0.
- Write 0x1A118000 with per_gnt_i[1] low for 4 cycles -> per_req_o=10 held, data_gnt_o=0 until grant, then WAIT_RESP; per_r_opc_i[1]=1 with valid -> data_r_opc_o=1.
- Access 0x00000000 (unmapped), aux=0xA -> data_gnt_o=1 same cycle; next cycle r_valid=1, opc=1, rdata 0xBAD_ACCE5, aux 0xA; per_req_o stays 0.
- TIMEOUT_CYCLES=8, granted P0, no response -> err_timeout_o pulse 8 cycles after grant, error response next cycle; later stray per_r_valid_i[0] produces no data_r_valid_o.
- Overlapping ranges P0=P1=[0x100,0x200), access 0x150 -> only per_req_o[0]; per_r_valid_i[1] during WAIT_RESP is ignored.
- rst_n low while in WAIT_RESP -> all outputs 0 asynchronously; after release, IDLE accepts a new request normally.
